// File: rtl/grf_wport_arbiter.sv
// Arbitrates the single GRF write port between W-stage writeback and buffered
// long-unit results, with a starvation bound on the buffered head.
module grf_wport_arbiter #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 2,
    parameter int MAXWAIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [2:0]       wb_addr_sel,
    input  logic             lu_valid,
    input  logic [4:0]       lu_addr,
    input  logic [WIDTH-1:0] lu_data,
    output logic             lu_ready,
    output logic             grf_we,
    output logic [2:0]       addr_sel,
    output logic [4:0]       buf_addr,
    output logic             wd_sel,
    output logic [WIDTH-1:0] buf_data,
    output logic             wb_stall,
    input  logic [4:0]       q_addr,
    output logic             q_pending
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int WW = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;
    localparam logic [CW-1:0] FULLCNT = CW'(DEPTH);
    localparam logic [WW-1:0] WMAX    = WW'(MAXWAIT);

    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

    state_t           state, state_nxt;
    logic [4:0]       addr_mem [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count, count_nxt;
    logic [WW-1:0]    wait_cnt, wait_nxt;
    logic             empty, full, head_grant, push_fire, push_store;

    assign empty      = (count == '0);
    assign full       = (count == FULLCNT);
    assign lu_ready   = !full && !reset;
    assign push_fire  = lu_valid && lu_ready;
    // Writes to $0 complete the handshake but are never worth buffering.
    assign push_store = push_fire && (lu_addr != 5'd0);

    always_comb begin
        count_nxt = count;
        if (push_store && !head_grant)
            count_nxt = count + CW'(1);
        else if (!push_store && head_grant)
            count_nxt = count - CW'(1);

        wait_nxt = wait_cnt;
        if (head_grant || empty)
            wait_nxt = '0;
        else if (wait_cnt != WMAX)
            wait_nxt = wait_cnt + WW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            if (push_store)
                wr_ptr <= wr_ptr + PW'(1);
            if (head_grant)
                rd_ptr <= rd_ptr + PW'(1);
            count    <= count_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_store) begin
            addr_mem[wr_ptr] <= lu_addr;
            data_mem[wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FORCE means the head must win next cycle regardless of the pipeline.
    always_comb begin
        state_nxt = PEND;
        if (count_nxt == '0)
            state_nxt = IDLE;
        else if ((count_nxt == FULLCNT) || (wait_nxt == WMAX))
            state_nxt = FORCE;
    end

    always_comb begin
        head_grant = 1'b0;
        grf_we     = 1'b0;
        addr_sel   = 3'd0;
        wd_sel     = 1'b0;
        wb_stall   = 1'b0;
        if (!reset) begin
            head_grant = (state == FORCE) || ((state == PEND) && !wb_valid);
            if (head_grant) begin
                grf_we   = 1'b1;
                addr_sel = 3'd7;
                wd_sel   = 1'b1;
                wb_stall = wb_valid;
            end else begin
                grf_we   = wb_valid;
                addr_sel = wb_addr_sel;
            end
        end
    end

    assign buf_addr = (reset || empty) ? 5'd0 : addr_mem[rd_ptr];
    assign buf_data = (reset || empty) ? '0 : data_mem[rd_ptr];

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PW-1:0] offs;
        q_pending = 1'b0;
        offs      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            if ((CW'(offs) < count) && (addr_mem[i] == q_addr))
                q_pending = 1'b1;
        end
        if (reset || (q_addr == 5'd0))
            q_pending = 1'b0;
    end

endmodule
